countdown_timer: RTL
====================

COUNTDOWN_TIMER -- requirements
Module: countdown_timer

Interface
REQ-001 Parameter CLK_HZ, default 50_000_000, input clock frequency in Hz; one-second tick period in cycles.
REQ-002 Parameter SCAN_DIV, default 12_500, cycles each digit is driven during display multiplexing.
REQ-003 Parameter BLINK_DIV, default 12_500_000, cycles per half-period of the expired-state blink.
REQ-004 Parameter ACTIVE_LOW, default 1; when 1, seg and sel are active-low; when 0, active-high.
REQ-005 clk  input  1  single system clock, all logic rising-edge.
REQ-006 rst_n  input  1  reset, asynchronous, active-low.
REQ-007 mode  input  1  0 = count up, 1 = count down; sampled only on load.
REQ-008 preset  input  14  BCD {min_h[13:11], min_l[10:7], sec_h[6:4], sec_l[3:0]}, captured on load.
REQ-009 load  input  1  single-cycle pulse: capture preset and mode, enter IDLE.
REQ-010 start  input  1  single-cycle pulse: begin or resume counting.
REQ-011 stop  input  1  single-cycle pulse: pause counting.
REQ-012 seg  output  8  segments {dp,g,f,e,d,c,b,a} of the currently selected digit.
REQ-013 sel  output  4  one-hot digit enable; sel[0]=sec_l, [1]=sec_h, [2]=min_l, [3]=min_h.
REQ-014 done  output  1  level, high while in DONE.
REQ-015 rollover  output  1  one-cycle pulse when up-count wraps 59:59 -> 00:00.

Function
REQ-016 FSM states IDLE, RUN, PAUSE, DONE; control priority load > stop > start when asserted together.
REQ-017 load from any state: time <= clamped preset, mode latched, state IDLE, prescaler cleared, next cycle.
REQ-018 Clamp: min_h/sec_h > 5 load as 5; min_l/sec_l > 9 load as 9; per digit, independently.
REQ-019 start in IDLE or PAUSE -> RUN; prescaler cleared on entry so the first tick is CLK_HZ cycles later.
REQ-020 start in IDLE, mode=1, time 00:00 -> DONE next cycle, no counting.
REQ-021 stop in RUN -> PAUSE; time held; stop in any other state ignored; start in RUN or DONE ignored.
REQ-022 Prescaler counts 0..CLK_HZ-1 in RUN only; tick asserted on the cycle it equals CLK_HZ-1; time updates on that edge.
REQ-023 Up-count: BCD ripple sec_l 9->0 carries to sec_h, sec_h 5->0 to min_l, min_l 9->0 to min_h, min_h 5->0.
REQ-024 Up-count 59:59 + tick -> 00:00, rollover pulsed the same cycle the time updates, state stays RUN.
REQ-025 Down-count: BCD borrow mirror of REQ-023; the tick producing 00:00 moves state to DONE on the same edge.
REQ-026 done = 1 exactly while state is DONE; DONE exits only via load.
REQ-027 Scan counter 0..SCAN_DIV-1 free-runs in all states; digit index 0->1->2->3->0 advances on wrap.
REQ-028 seg shows the 7-seg code of the selected digit; dp lit only on digit 2 (min_l) as the colon, and blinks with the 1 Hz tick phase while RUN.
REQ-029 In DONE, blink counter toggles a phase every BLINK_DIV cycles; during the off phase seg is all segments off; sel continues scanning.
REQ-030 seg and sel are registered; polarity applied per ACTIVE_LOW at the output register.

Reset
REQ-031 On rst_n low, asynchronously: state IDLE, time 00:00, mode 0 (up), prescaler/scan/blink counters 0, blink phase on.
REQ-032 During reset: done 0, rollover 0, sel = digit 0 enabled, seg = all segments off (ACTIVE_LOW=1: sel 4'b1110, seg 8'hFF).
REQ-033 Reset assertion mid-count discards time and state; no tick, rollover or done is produced on release.

Structure
REQ-034 Shared package timer_pkg holds the state enum, 7-seg code table for 0-9, blank code and BCD digit limits.
REQ-035 One sub-module seg7_scan: scan counter, digit mux, decode, dp and blink masking, polarity; the counter/FSM stays in countdown_timer.

Verification (CLK_HZ=10, SCAN_DIV=2, BLINK_DIV=5, ACTIVE_LOW=1)
REQ-036 load preset 00:03 mode=1, start -> after 30 cycles time 00:00, done=1 on that edge, seg blanks every 5 cycles.
REQ-037 load 59:58 mode=0, start -> after 20 cycles time 00:00, rollover high exactly one cycle, state RUN.
REQ-038 load 09:59 mode=0, start, stop after 15 cycles -> time 10:00 held for 100 cycles; start -> 10:01 after 10 more cycles.
REQ-039 load preset 14'h3FFF (digits 7,15,7,15) -> time reads 59:59; load+start same cycle -> IDLE, no count.
REQ-040 load 00:00 mode=1, start -> done=1 next cycle, no tick counted.
REQ-041 rst_n low mid-RUN at 05:30 -> immediately sel=1110, seg=FF, done=0; after release time 00:00, IDLE.

Source files
------------

// File: rtl/timer_pkg.sv
// Shared types, limits and 7-segment table for the countdown timer.
package timer_pkg;

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StRun   = 2'd1,
        StPause = 2'd2,
        StDone  = 2'd3
    } state_e;

    // Layout matches the preset input bit for bit.
    typedef struct packed {
        logic [2:0] min_h;
        logic [3:0] min_l;
        logic [2:0] sec_h;
        logic [3:0] sec_l;
    } bcd_time_t;

    localparam logic [3:0] LO_DIGIT_MAX = 4'd9;
    localparam logic [2:0] HI_DIGIT_MAX = 3'd5;

    // Active-high {g,f,e,d,c,b,a}.
    localparam logic [6:0] SEG_BLANK = 7'h00;

    function automatic logic [6:0] seg7_code(input logic [3:0] d);
        logic [6:0] c;
        case (d)
            4'd0:    c = 7'h3F;
            4'd1:    c = 7'h06;
            4'd2:    c = 7'h5B;
            4'd3:    c = 7'h4F;
            4'd4:    c = 7'h66;
            4'd5:    c = 7'h6D;
            4'd6:    c = 7'h7D;
            4'd7:    c = 7'h07;
            4'd8:    c = 7'h7F;
            4'd9:    c = 7'h6F;
            default: c = SEG_BLANK;
        endcase
        return c;
    endfunction

    // Each digit saturates at its own limit, independently of the others.
    function automatic bcd_time_t clamp_time(input logic [13:0] p);
        bcd_time_t t;
        t = p;
        if (t.min_h > HI_DIGIT_MAX) t.min_h = HI_DIGIT_MAX;
        if (t.min_l > LO_DIGIT_MAX) t.min_l = LO_DIGIT_MAX;
        if (t.sec_h > HI_DIGIT_MAX) t.sec_h = HI_DIGIT_MAX;
        if (t.sec_l > LO_DIGIT_MAX) t.sec_l = LO_DIGIT_MAX;
        return t;
    endfunction

endpackage

// File: rtl/seg7_scan.sv
// Multiplexed 4-digit 7-segment driver with colon dp and expired-state blink.
module seg7_scan
    import timer_pkg::*;
#(
    parameter int unsigned SCAN_DIV   = 12_500,
    parameter int unsigned BLINK_DIV  = 12_500_000,
    parameter int unsigned ACTIVE_LOW = 1
) (
    input  logic      clk,
    input  logic      rst_n,
    input  bcd_time_t i_time,
    input  logic      i_dp_on,
    input  logic      i_blink_en,
    output logic [7:0] o_seg,
    output logic [3:0] o_sel
);

    localparam int SW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int BW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
    localparam logic POL_LOW = (ACTIVE_LOW != 0);

    logic [SW-1:0] r_scan_cnt;
    logic [1:0]    r_digit;
    logic [BW-1:0] r_blink_cnt;
    logic          r_phase_on;
    logic [7:0]    r_seg;
    logic [3:0]    r_sel;

    logic [3:0]    w_bcd;
    logic [7:0]    w_seg_hi;
    logic [3:0]    w_sel_hi;

    // Free-running scan prescaler; digit index advances on each wrap.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_scan_cnt <= '0;
            r_digit    <= 2'd0;
        end else if (r_scan_cnt == SW'(SCAN_DIV - 1)) begin
            r_scan_cnt <= '0;
            r_digit    <= r_digit + 2'd1;
        end else begin
            r_scan_cnt <= r_scan_cnt + SW'(1);
        end
    end

    // Blink phase runs only while expired; parked at "on" otherwise so it restarts cleanly.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_blink_cnt <= '0;
            r_phase_on  <= 1'b1;
        end else if (!i_blink_en) begin
            r_blink_cnt <= '0;
            r_phase_on  <= 1'b1;
        end else if (r_blink_cnt == BW'(BLINK_DIV - 1)) begin
            r_blink_cnt <= '0;
            r_phase_on  <= ~r_phase_on;
        end else begin
            r_blink_cnt <= r_blink_cnt + BW'(1);
        end
    end

    // Digit mux, decode and masking in active-high form.
    always_comb begin
        case (r_digit)
            2'd0:    w_bcd = i_time.sec_l;
            2'd1:    w_bcd = {1'b0, i_time.sec_h};
            2'd2:    w_bcd = i_time.min_l;
            default: w_bcd = {1'b0, i_time.min_h};
        endcase
        w_seg_hi = {(r_digit == 2'd2) && i_dp_on, seg7_code(w_bcd)};
        if (i_blink_en && !r_phase_on) begin
            w_seg_hi = {1'b0, SEG_BLANK};
        end
        w_sel_hi = 4'b0001 << r_digit;
    end

    // Output registers with polarity applied here.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_seg <= POL_LOW ? 8'hFF : 8'h00;
            r_sel <= POL_LOW ? 4'b1110 : 4'b0001;
        end else begin
            r_seg <= POL_LOW ? ~w_seg_hi : w_seg_hi;
            r_sel <= POL_LOW ? ~w_sel_hi : w_sel_hi;
        end
    end

    assign o_seg = r_seg;
    assign o_sel = r_sel;

endmodule

// File: rtl/countdown_timer.sv
// MM:SS up/down timer with load/start/stop control and multiplexed display.
module countdown_timer
    import timer_pkg::*;
#(
    parameter int unsigned CLK_HZ     = 50_000_000,
    parameter int unsigned SCAN_DIV   = 12_500,
    parameter int unsigned BLINK_DIV  = 12_500_000,
    parameter int unsigned ACTIVE_LOW = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        mode,
    input  logic [13:0] preset,
    input  logic        load,
    input  logic        start,
    input  logic        stop,
    output logic [7:0]  seg,
    output logic [3:0]  sel,
    output logic        done,
    output logic        rollover
);

    localparam int PW = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;

    state_e    r_state;
    bcd_time_t r_time;
    logic      r_mode;
    logic [PW-1:0] r_presc;
    logic      r_rollover;

    logic      w_tick;
    logic      w_wrap;
    logic      w_dp_on;
    bcd_time_t w_time_inc;
    bcd_time_t w_time_dec;

    assign w_tick  = (r_state == StRun) && (r_presc == PW'(CLK_HZ - 1));
    // Colon blinks with the second phase while running, steady otherwise.
    assign w_dp_on = (r_state != StRun) || (r_presc < PW'(CLK_HZ / 2));

    // BCD ripple increment; flags the 59:59 -> 00:00 wrap.
    always_comb begin
        w_time_inc = r_time;
        w_wrap     = 1'b0;
        if (r_time.sec_l != LO_DIGIT_MAX) begin
            w_time_inc.sec_l = r_time.sec_l + 4'd1;
        end else begin
            w_time_inc.sec_l = '0;
            if (r_time.sec_h != HI_DIGIT_MAX) begin
                w_time_inc.sec_h = r_time.sec_h + 3'd1;
            end else begin
                w_time_inc.sec_h = '0;
                if (r_time.min_l != LO_DIGIT_MAX) begin
                    w_time_inc.min_l = r_time.min_l + 4'd1;
                end else begin
                    w_time_inc.min_l = '0;
                    if (r_time.min_h != HI_DIGIT_MAX) begin
                        w_time_inc.min_h = r_time.min_h + 3'd1;
                    end else begin
                        w_time_inc.min_h = '0;
                        w_wrap           = 1'b1;
                    end
                end
            end
        end
    end

    // BCD ripple decrement with borrow; never evaluated at 00:00 while running.
    always_comb begin
        w_time_dec = r_time;
        if (r_time.sec_l != 4'd0) begin
            w_time_dec.sec_l = r_time.sec_l - 4'd1;
        end else begin
            w_time_dec.sec_l = LO_DIGIT_MAX;
            if (r_time.sec_h != 3'd0) begin
                w_time_dec.sec_h = r_time.sec_h - 3'd1;
            end else begin
                w_time_dec.sec_h = HI_DIGIT_MAX;
                if (r_time.min_l != 4'd0) begin
                    w_time_dec.min_l = r_time.min_l - 4'd1;
                end else begin
                    w_time_dec.min_l = LO_DIGIT_MAX;
                    if (r_time.min_h != 3'd0) begin
                        w_time_dec.min_h = r_time.min_h - 3'd1;
                    end else begin
                        w_time_dec.min_h = HI_DIGIT_MAX;
                    end
                end
            end
        end
    end

    // Control FSM, one-second prescaler and time register; load > stop > start.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= StIdle;
            r_time     <= '0;
            r_mode     <= 1'b0;
            r_presc    <= '0;
            r_rollover <= 1'b0;
        end else begin
            r_rollover <= 1'b0;
            if (load) begin
                r_time  <= clamp_time(preset);
                r_mode  <= mode;
                r_state <= StIdle;
                r_presc <= '0;
            end else if (stop) begin
                if (r_state == StRun) r_state <= StPause;
            end else if (start && (r_state == StIdle || r_state == StPause)) begin
                r_presc <= '0;
                if (r_state == StIdle && r_mode && r_time == '0) begin
                    r_state <= StDone;
                end else begin
                    r_state <= StRun;
                end
            end else if (r_state == StRun) begin
                if (w_tick) begin
                    r_presc <= '0;
                    if (!r_mode) begin
                        r_time     <= w_time_inc;
                        r_rollover <= w_wrap;
                    end else begin
                        r_time <= w_time_dec;
                        if (w_time_dec == '0) r_state <= StDone;
                    end
                end else begin
                    r_presc <= r_presc + PW'(1);
                end
            end
        end
    end

    assign done     = (r_state == StDone);
    assign rollover = r_rollover;

    seg7_scan #(
        .SCAN_DIV   (SCAN_DIV),
        .BLINK_DIV  (BLINK_DIV),
        .ACTIVE_LOW (ACTIVE_LOW)
    ) u_scan (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_time     (r_time),
        .i_dp_on    (w_dp_on),
        .i_blink_en (done),
        .o_seg      (seg),
        .o_sel      (sel)
    );

endmodule
